// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and board-top defaults for the PLL lock sequencer.
package pll_lock_sequencer_pkg;

    // Sequencer states: wait for sync'd lock, qualify it, stagger releases, run.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    // Defaults used by board tops that instantiate the sequencer unmodified.
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_NUM_RESETS     = 3;
    localparam int DEF_STAGGER_CYCLES = 16;
    localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Lock input, control requests and status/reset outputs of the sequencer.
interface pll_lock_sequencer_if
    import pll_lock_sequencer_pkg::*;
#(
    parameter int NUM_RESETS = DEF_NUM_RESETS,
    parameter int CNT_W      = DEF_CNT_W
);
    logic                  pll_locked_in;
    logic                  soft_rst_in;
    logic                  clr_stats_in;
    logic                  locked;
    logic [NUM_RESETS-1:0] rst_out;
    logic                  ready;
    logic [CNT_W-1:0]      lock_loss_cnt;
    logic                  lock_lost_sticky;

    // Board top / bench side: drives lock and requests, observes status.
    modport master (
        output pll_locked_in, soft_rst_in, clr_stats_in,
        input  locked, rst_out, ready, lock_loss_cnt, lock_lost_sticky
    );

    // Sequencer side.
    modport slave (
        input  pll_locked_in, soft_rst_in, clr_stats_in,
        output locked, rst_out, ready, lock_loss_cnt, lock_lost_sticky
    );
endinterface

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser with asynchronous active-low clear.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one stage further down the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser chain flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pll_lock_sequencer.sv
// Qualifies the PLL lock flag, releases domain resets in staggered order,
// and tracks lock-loss statistics. All outputs come straight from flops.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int NUM_RESETS     = DEF_NUM_RESETS,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                clock_in,
    input  logic                rst_in,
    pll_lock_sequencer_if.slave bus
);
    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int STG_W = $clog2(STAGGER_CYCLES + 1);
    localparam int IDX_W = $clog2(NUM_RESETS + 1);

    localparam logic [STB_W-1:0] STABLE_TC  = STB_W'(STABLE_CYCLES);
    localparam logic [STG_W-1:0] STAGGER_TC = STG_W'(STAGGER_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_RESETS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic                  lock_s;
    logic                  loss_event;
    seq_state_t            state_q, state_d;
    logic [STB_W-1:0]      stable_cnt_q, stable_cnt_d;
    logic [STG_W-1:0]      stagger_cnt_q, stagger_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  locked_q, locked_d;
    logic [NUM_RESETS-1:0] rst_out_q, rst_out_d;
    logic                  ready_q, ready_d;
    logic [CNT_W-1:0]      loss_cnt_q, loss_cnt_d;
    logic                  sticky_q, sticky_d;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clock_in),
        .rst_n (rst_in),
        .d     (bus.pll_locked_in),
        .q     (lock_s)
    );

    // Sequencer next state: qualification window, staggered release, loss and soft restart.
    always_comb begin
        state_d       = state_q;
        stable_cnt_d  = stable_cnt_q;
        stagger_cnt_d = stagger_cnt_q;
        idx_d         = idx_q;
        locked_d      = locked_q;
        rst_out_d     = rst_out_q;
        ready_d       = ready_q;
        loss_event    = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                locked_d      = 1'b0;
                rst_out_d     = '1;
                ready_d       = 1'b0;
                stable_cnt_d  = '0;
                stagger_cnt_d = '0;
                idx_d         = '0;
                if (lock_s) begin
                    // A one-cycle window is already satisfied by this first high sample.
                    if (STABLE_TC == STB_W'(1)) begin
                        locked_d = 1'b1;
                        state_d  = RELEASE;
                    end else begin
                        stable_cnt_d = STB_W'(1);
                        state_d      = STABLE;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    // Dropping out before qualification is a glitch, not a loss.
                    stable_cnt_d = '0;
                    state_d      = WAIT_LOCK;
                end else if (stable_cnt_q + STB_W'(1) == STABLE_TC) begin
                    stable_cnt_d  = '0;
                    stagger_cnt_d = '0;
                    idx_d         = '0;
                    locked_d      = 1'b1;
                    state_d       = RELEASE;
                end else begin
                    stable_cnt_d = stable_cnt_q + STB_W'(1);
                end
            end
            RELEASE, RUN: begin
                if (!lock_s) begin
                    loss_event    = 1'b1;
                    locked_d      = 1'b0;
                    rst_out_d     = '1;
                    ready_d       = 1'b0;
                    stable_cnt_d  = '0;
                    stagger_cnt_d = '0;
                    idx_d         = '0;
                    state_d       = WAIT_LOCK;
                end else if (bus.soft_rst_in) begin
                    // Re-run the release sequence while keeping the qualified lock.
                    rst_out_d     = '1;
                    ready_d       = 1'b0;
                    stagger_cnt_d = '0;
                    idx_d         = '0;
                    state_d       = RELEASE;
                end else if (state_q == RELEASE) begin
                    if (stagger_cnt_q + STG_W'(1) == STAGGER_TC) begin
                        // Bit 0 goes first, so shifting left releases the next lowest reset.
                        stagger_cnt_d = '0;
                        rst_out_d     = rst_out_q << 1;
                        idx_d         = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            ready_d = 1'b1;
                            state_d = RUN;
                        end
                    end else begin
                        stagger_cnt_d = stagger_cnt_q + STG_W'(1);
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // Lock-loss statistics: clear applies first, then a coincident loss is counted.
    always_comb begin
        loss_cnt_d = bus.clr_stats_in ? '0 : loss_cnt_q;
        sticky_d   = bus.clr_stats_in ? 1'b0 : sticky_q;
        if (loss_event) begin
            sticky_d = 1'b1;
            if (loss_cnt_d != CNT_MAX) loss_cnt_d = loss_cnt_d + CNT_W'(1);
        end
    end

    // State, counters, outputs and stats registers.
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= WAIT_LOCK;
            stable_cnt_q  <= '0;
            stagger_cnt_q <= '0;
            idx_q         <= '0;
            locked_q      <= 1'b0;
            rst_out_q     <= '1;
            ready_q       <= 1'b0;
            loss_cnt_q    <= '0;
            sticky_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            stable_cnt_q  <= stable_cnt_d;
            stagger_cnt_q <= stagger_cnt_d;
            idx_q         <= idx_d;
            locked_q      <= locked_d;
            rst_out_q     <= rst_out_d;
            ready_q       <= ready_d;
            loss_cnt_q    <= loss_cnt_d;
            sticky_q      <= sticky_d;
        end
    end

    assign bus.locked           = locked_q;
    assign bus.rst_out          = rst_out_q;
    assign bus.ready            = ready_q;
    assign bus.lock_loss_cnt    = loss_cnt_q;
    assign bus.lock_lost_sticky = sticky_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with SYNC=2, STABLE=8, RESETS=3, STAGGER=4, CNT_W=2.
module tb_pll_lock_sequencer;

    logic clock_in;
    logic rst_in;
    int   n_checks;
    int   n_pass;

    pll_lock_sequencer_if #(.NUM_RESETS(3), .CNT_W(2)) bus ();

    pll_lock_sequencer #(
        .SYNC_STAGES    (2),
        .STABLE_CYCLES  (8),
        .NUM_RESETS     (3),
        .STAGGER_CYCLES (4),
        .CNT_W          (2)
    ) dut (
        .clock_in (clock_in),
        .rst_in   (rst_in),
        .bus      (bus)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Expected outputs N edges after pll_locked_in rises (just after edge 0).
    typedef struct {
        int         edge_n;
        logic       locked;
        logic [2:0] rst;
        logic       ready;
    } lock_vec_t;

    lock_vec_t lock_tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic run_lock_table(input string tag);
        int cur;
        cur = 0;
        for (int i = 0; i < 9; i++) begin
            while (cur < lock_tbl[i].edge_n) begin
                step();
                cur++;
            end
            check({tag, " locked"}, 32'(bus.locked),  32'(lock_tbl[i].locked));
            check({tag, " rst_out"}, 32'(bus.rst_out), 32'(lock_tbl[i].rst));
            check({tag, " ready"},  32'(bus.ready),   32'(lock_tbl[i].ready));
            $display("%s edge %0d: locked=%b rst_out=%b ready=%b", tag, cur,
                     bus.locked, bus.rst_out, bus.ready);
        end
    endtask

    // Drop lock long enough to reach WAIT_LOCK, then relock and reach RELEASE.
    task automatic loss_relock();
        bus.pll_locked_in = 1'b0;
        repeat (4) step();
        check("loss_relock dropped", 32'(bus.locked), 32'd0);
        bus.pll_locked_in = 1'b1;
        repeat (12) step();
        check("loss_relock relocked", 32'(bus.locked), 32'd1);
    endtask

    initial begin
        logic [1:0] exp_cnt;
        n_checks = 0;
        n_pass   = 0;
        lock_tbl[0] = '{9,  1'b0, 3'b111, 1'b0};
        lock_tbl[1] = '{10, 1'b1, 3'b111, 1'b0};
        lock_tbl[2] = '{13, 1'b1, 3'b111, 1'b0};
        lock_tbl[3] = '{14, 1'b1, 3'b110, 1'b0};
        lock_tbl[4] = '{17, 1'b1, 3'b110, 1'b0};
        lock_tbl[5] = '{18, 1'b1, 3'b100, 1'b0};
        lock_tbl[6] = '{21, 1'b1, 3'b100, 1'b0};
        lock_tbl[7] = '{22, 1'b1, 3'b000, 1'b1};
        lock_tbl[8] = '{25, 1'b1, 3'b000, 1'b1};

        rst_in            = 1'b0;
        bus.pll_locked_in = 1'b0;
        bus.soft_rst_in   = 1'b0;
        bus.clr_stats_in  = 1'b0;
        #12;
        check("reset locked", 32'(bus.locked), 32'd0);
        check("reset rst_out", 32'(bus.rst_out), 32'h7);
        check("reset ready", 32'(bus.ready), 32'd0);
        check("reset cnt", 32'(bus.lock_loss_cnt), 32'd0);
        check("reset sticky", 32'(bus.lock_lost_sticky), 32'd0);
        $display("reset: locked=%b rst_out=%b", bus.locked, bus.rst_out);
        step();
        rst_in = 1'b1;

        // Glitch: lock high for 5 cycles never qualifies.
        bus.pll_locked_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 5) bus.pll_locked_in = 1'b0;
            check("glitch locked", 32'(bus.locked), 32'd0);
            check("glitch rst_out", 32'(bus.rst_out), 32'h7);
            check("glitch ready", 32'(bus.ready), 32'd0);
        end
        check("glitch cnt", 32'(bus.lock_loss_cnt), 32'd0);
        check("glitch sticky", 32'(bus.lock_lost_sticky), 32'd0);
        $display("glitch: locked=%b cnt=%0d", bus.locked, bus.lock_loss_cnt);

        // Clean lock.
        bus.pll_locked_in = 1'b1;
        run_lock_table("clean");

        // Loss in RUN: effect on the third edge after the drop.
        bus.pll_locked_in = 1'b0;
        step();
        step();
        check("loss early locked", 32'(bus.locked), 32'd1);
        check("loss early rst_out", 32'(bus.rst_out), 32'h0);
        step();
        check("loss locked", 32'(bus.locked), 32'd0);
        check("loss rst_out", 32'(bus.rst_out), 32'h7);
        check("loss ready", 32'(bus.ready), 32'd0);
        check("loss cnt", 32'(bus.lock_loss_cnt), 32'd1);
        check("loss sticky", 32'(bus.lock_lost_sticky), 32'd1);
        $display("loss: rst_out=%b cnt=%0d", bus.rst_out, bus.lock_loss_cnt);

        // Relock repeats the clean timing.
        bus.pll_locked_in = 1'b1;
        run_lock_table("relock");
        check("relock cnt", 32'(bus.lock_loss_cnt), 32'd1);

        // Soft reset in RUN.
        bus.soft_rst_in = 1'b1;
        step();
        bus.soft_rst_in = 1'b0;
        check("soft rst_out", 32'(bus.rst_out), 32'h7);
        check("soft locked", 32'(bus.locked), 32'd1);
        check("soft ready", 32'(bus.ready), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            case (k)
                3:  check("soft +3 rst_out", 32'(bus.rst_out), 32'h7);
                4:  check("soft +4 rst_out", 32'(bus.rst_out), 32'h6);
                7:  check("soft +7 rst_out", 32'(bus.rst_out), 32'h6);
                8:  check("soft +8 rst_out", 32'(bus.rst_out), 32'h4);
                11: check("soft +11 ready", 32'(bus.ready), 32'd0);
                12: begin
                    check("soft +12 rst_out", 32'(bus.rst_out), 32'h0);
                    check("soft +12 ready", 32'(bus.ready), 32'd1);
                end
                default: ;
            endcase
        end
        check("soft cnt", 32'(bus.lock_loss_cnt), 32'd1);
        $display("soft: rst_out=%b locked=%b cnt=%0d", bus.rst_out, bus.locked, bus.lock_loss_cnt);

        // Saturation of the 2-bit counter.
        exp_cnt = 2'd1;
        for (int n = 0; n < 5; n++) begin
            loss_relock();
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            check("sat cnt", 32'(bus.lock_loss_cnt), 32'(exp_cnt));
            $display("sat loop %0d: cnt=%0d", n, bus.lock_loss_cnt);
        end
        check("sat sticky", 32'(bus.lock_lost_sticky), 32'd1);

        // Clear alone.
        bus.clr_stats_in = 1'b1;
        step();
        bus.clr_stats_in = 1'b0;
        check("clr cnt", 32'(bus.lock_loss_cnt), 32'd0);
        check("clr sticky", 32'(bus.lock_lost_sticky), 32'd0);
        check("clr locked", 32'(bus.locked), 32'd1);
        $display("clr: cnt=%0d sticky=%b", bus.lock_loss_cnt, bus.lock_lost_sticky);

        // Clear coincident with a loss (and a soft request that must lose).
        loss_relock();
        loss_relock();
        check("pre-coinc cnt", 32'(bus.lock_loss_cnt), 32'd2);
        bus.pll_locked_in = 1'b0;
        step();
        step();
        bus.clr_stats_in = 1'b1;
        bus.soft_rst_in  = 1'b1;
        step();
        bus.clr_stats_in = 1'b0;
        bus.soft_rst_in  = 1'b0;
        check("coinc cnt", 32'(bus.lock_loss_cnt), 32'd1);
        check("coinc sticky", 32'(bus.lock_lost_sticky), 32'd1);
        check("coinc locked", 32'(bus.locked), 32'd0);
        check("coinc rst_out", 32'(bus.rst_out), 32'h7);
        $display("coinc: cnt=%0d sticky=%b locked=%b", bus.lock_loss_cnt,
                 bus.lock_lost_sticky, bus.locked);

        // Async reset mid-RELEASE.
        bus.pll_locked_in = 1'b1;
        repeat (14) step();
        check("pre-areset rst_out", 32'(bus.rst_out), 32'h6);
        check("pre-areset locked", 32'(bus.locked), 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check("areset locked", 32'(bus.locked), 32'd0);
        check("areset rst_out", 32'(bus.rst_out), 32'h7);
        check("areset ready", 32'(bus.ready), 32'd0);
        check("areset cnt", 32'(bus.lock_loss_cnt), 32'd0);
        check("areset sticky", 32'(bus.lock_lost_sticky), 32'd0);
        $display("areset: locked=%b rst_out=%b", bus.locked, bus.rst_out);
        step();
        rst_in = 1'b1;
        run_lock_table("post-areset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
